mem_bus_arbiter: RTL

- Shares one Avalon-style memory slave port between the CPU instruction bus (read-only) and data bus (read/write with byte enables).
- Sits between the CPU top level and the SOC memory/interconnect.
- Grants one master at a time through a small registered-grant FSM and holds the grant until the slave completes the access.
- Includes a per-access watchdog that aborts hung slave accesses and flags a sticky bus error.

---
 rtl/cpu_bus_pkg.sv | 11 +
 rtl/mem_bus_arbiter_if.sv | 40 ++++
 rtl/mem_bus_watchdog.sv | 36 +++
 rtl/mem_bus_arbiter.sv | 71 +++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared types and constants for the memory bus arbiter.
//   arb_state_e : grant FSM states (IDLE / GRANT_I / GRANT_D)
//   ABORT_DATA  : read data returned to a master on a watchdog abort
//   ADDR_W/DATA_W/BE_W : word address, data and byte-enable widths
package cpu_bus_pkg;
    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;
    localparam int BE_W = 4;
    localparam logic [DATA_W-1:0] ABORT_DATA = 32'hDEADBEEF;
    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} arb_state_e;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: instruction bus, data bus and memory slave port bundle.
//   i_IBus_* / o_IBus_* : instruction master (read-only)
//   i_DBus_* / o_DBus_* : data master (read/write with byte enables)
//   o_Mem_* / i_Mem_*   : shared Avalon-style slave port
//   o_BusErr            : sticky watchdog-abort flag
//   modport slave  : arbiter side; modport master : environment side
interface mem_bus_arbiter_if;
    import cpu_bus_pkg::*;
    logic [ADDR_W-1:0] i_IBus_Address;
    logic              i_IBus_Read;
    logic [DATA_W-1:0] o_IBus_ReadData;
    logic              o_IBus_WaitReq;
    logic [ADDR_W-1:0] i_DBus_Address;
    logic [BE_W-1:0]   i_DBus_ByteEn;
    logic              i_DBus_Read;
    logic              i_DBus_Write;
    logic [DATA_W-1:0] i_DBus_WriteData;
    logic [DATA_W-1:0] o_DBus_ReadData;
    logic              o_DBus_WaitReq;
    logic [ADDR_W-1:0] o_Mem_Address;
    logic [BE_W-1:0]   o_Mem_ByteEn;
    logic              o_Mem_Read;
    logic              o_Mem_Write;
    logic [DATA_W-1:0] o_Mem_WriteData;
    logic [DATA_W-1:0] i_Mem_ReadData;
    logic              i_Mem_WaitReq;
    logic              o_BusErr;
    modport slave (
        input  i_IBus_Address, i_IBus_Read, i_DBus_Address, i_DBus_ByteEn,
               i_DBus_Read, i_DBus_Write, i_DBus_WriteData, i_Mem_ReadData, i_Mem_WaitReq,
        output o_IBus_ReadData, o_IBus_WaitReq, o_DBus_ReadData, o_DBus_WaitReq,
               o_Mem_Address, o_Mem_ByteEn, o_Mem_Read, o_Mem_Write, o_Mem_WriteData, o_BusErr
    );
    modport master (
        output i_IBus_Address, i_IBus_Read, i_DBus_Address, i_DBus_ByteEn,
               i_DBus_Read, i_DBus_Write, i_DBus_WriteData, i_Mem_ReadData, i_Mem_WaitReq,
        input  o_IBus_ReadData, o_IBus_WaitReq, o_DBus_ReadData, o_DBus_WaitReq,
               o_Mem_Address, o_Mem_ByteEn, o_Mem_Read, o_Mem_Write, o_Mem_WriteData, o_BusErr
    );
endinterface

// File: rtl/mem_bus_watchdog.sv
// mem_bus_watchdog: per-access stall counter with forced abort and sticky error.
//   clk, rst     : clock, asynchronous active-high reset
//   grant_active : a master currently holds the grant
//   mem_waitreq  : slave stall
//   clear        : restart the count (held while no grant is active)
//   abort        : this cycle is a forced completion
//   err          : sticky abort flag, cleared only by rst
module mem_bus_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic grant_active,
    input  logic mem_waitreq,
    input  logic clear,
    output logic abort,
    output logic err
);
    logic [31:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    always_comb begin
        cnt_d = clear ? 32'd0 : (grant_active && mem_waitreq) ? cnt_q + 32'd1 : cnt_q;
        abort = grant_active && (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_CYCLES);
        err_d = err_q | abort;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory slave port between the instruction and data buses.
//   i_Clk, i_Rst : clock, asynchronous active-high reset
//   bus          : mem_bus_arbiter_if.slave (both master ports, slave port, o_BusErr)
//   TIMEOUT_CYCLES : slave wait cycles per access before abort (0 disables)
//   ARB_ROUND_ROBIN_EN : when defined, ties alternate; otherwise DBus always wins
module mem_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    mem_bus_arbiter_if.slave bus
);
    arb_state_e state_q, state_d;
    logic i_req, d_req, gi, gd, abort, done, tie_to_d;
`ifdef ARB_ROUND_ROBIN_EN
    // 1 = DBus was granted last; reset value means IBus last, so DBus wins the first tie
    logic last_d_q, last_d_d;
    assign tie_to_d = ~last_d_q;
    assign last_d_d = (state_q == IDLE && state_d != IDLE) ? (state_d == GRANT_D) : last_d_q;
`else
    assign tie_to_d = 1'b1;
`endif
    assign i_req = bus.i_IBus_Read;
    assign d_req = bus.i_DBus_Read | bus.i_DBus_Write;
    assign gi = state_q == GRANT_I;
    assign gd = state_q == GRANT_D;
    // A watchdog abort completes the access even while the slave still stalls
    assign done = abort | ~bus.i_Mem_WaitReq;
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE)
            state_d = (i_req && d_req) ? (tie_to_d ? GRANT_D : GRANT_I) :
                      i_req ? GRANT_I : d_req ? GRANT_D : IDLE;
        else if (done)
            state_d = IDLE;
    end
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q <= last_d_d;
`endif
        end
    end
    // Slave side is a pure function of the grant state, so reset drops strobes immediately
    assign bus.o_Mem_Address   = gi ? bus.i_IBus_Address : gd ? bus.i_DBus_Address : '0;
    assign bus.o_Mem_ByteEn    = gi ? 4'hF : gd ? bus.i_DBus_ByteEn : 4'h0;
    assign bus.o_Mem_Read      = (gi | (gd & bus.i_DBus_Read)) & ~abort;
    assign bus.o_Mem_Write     = gd & bus.i_DBus_Write & ~abort;
    assign bus.o_Mem_WriteData = gd ? bus.i_DBus_WriteData : '0;
    assign bus.o_IBus_WaitReq  = ~(gi & done);
    assign bus.o_DBus_WaitReq  = ~(gd & done);
    assign bus.o_IBus_ReadData = abort ? ABORT_DATA : bus.i_Mem_ReadData;
    assign bus.o_DBus_ReadData = abort ? ABORT_DATA : bus.i_Mem_ReadData;
    mem_bus_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
        .clk          (i_Clk),
        .rst          (i_Rst),
        .grant_active (gi | gd),
        .mem_waitreq  (bus.i_Mem_WaitReq),
        .clear        (state_q == IDLE),
        .abort        (abort),
        .err          (bus.o_BusErr)
    );
endmodule
